// File: rtl/clock_divider_multi_if.sv
// Bundles the divider's run controls, config write port and divided outputs.
// master drives enables/config and observes outputs; slave is the divider itself.
interface clock_divider_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] ch_enable;
    logic              sync_restart;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] slow_clock;
    logic [NUM_CH-1:0] tick;
    logic              cfg_err;

    modport master (
        output ch_enable, sync_restart, cfg_we, cfg_ch, cfg_div, cfg_mode,
        input  slow_clock, tick, cfg_err
    );

    modport slave (
        input  ch_enable, sync_restart, cfg_we, cfg_ch, cfg_div, cfg_mode,
        output slow_clock, tick, cfg_err
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per channel a divide ratio D, a
// toggle (50% clock, period 2D) or pulse (1-cycle high, period D) mode, and an enable.
module clock_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 31250,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    clock_divider_multi_if.slave  bus
);
    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  div_d   [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] slow_clock_q, slow_clock_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_valid;

    always_comb begin
        cfg_valid = bus.cfg_we && (32'(bus.cfg_ch) < NUM_CH) && (bus.cfg_div != '0);
        cfg_err_d = bus.cfg_we && !cfg_valid;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_d[i]        = div_q[i];
            mode_d[i]       = mode_q[i];
            count_d[i]      = count_q[i];
            slow_clock_d[i] = slow_clock_q[i];
            tick_d[i]       = 1'b0;
            // A valid write restarts its own channel; sync_restart restarts the rest.
            if (cfg_valid && (32'(bus.cfg_ch) == i)) begin
                div_d[i]        = bus.cfg_div;
                mode_d[i]       = bus.cfg_mode;
                count_d[i]      = '0;
                slow_clock_d[i] = 1'b0;
            end else if (bus.sync_restart) begin
                count_d[i]      = '0;
                slow_clock_d[i] = 1'b0;
            end else if (bus.ch_enable[i]) begin
                if (count_q[i] == div_q[i] - CNT_W'(1)) begin
                    count_d[i]      = '0;
                    tick_d[i]       = 1'b1;
                    slow_clock_d[i] = mode_q[i] ? 1'b1 : ~slow_clock_q[i];
                end else begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                    if (mode_q[i]) begin
                        slow_clock_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                count_q[i] <= '0;
            end
            mode_q       <= '0;
            slow_clock_q <= '0;
            tick_q       <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= div_d[i];
                count_q[i] <= count_d[i];
            end
            mode_q       <= mode_d;
            slow_clock_q <= slow_clock_d;
            tick_q       <= tick_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.slow_clock = slow_clock_q;
    assign bus.tick       = tick_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: a 4-channel default-sized instance driven
// from a cycle-by-cycle vector table, plus a 3-channel instance for channel-range rejection.
module tb_clock_divider_multi;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    clock_divider_multi_if #(.NUM_CH(4), .CNT_W(24), .CH_W(2)) bus ();
    clock_divider_multi_if #(.NUM_CH(3), .CNT_W(8), .CH_W(2))  bus3 ();

    clock_divider_multi #(
        .NUM_CH(4), .CNT_W(24), .DEFAULT_DIV(31250), .CH_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    clock_divider_multi #(
        .NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(2), .CH_W(2)
    ) dut3 (
        .clock(clock),
        .reset(reset),
        .bus(bus3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  en;
        logic        sync;
        logic        we;
        logic [1:0]  ch;
        logic [23:0] div;
        logic        mode;
        logic [3:0]  exp_slow;
        logic [3:0]  exp_tick;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] en, logic sync, logic we, logic [1:0] ch,
                                logic [23:0] div, logic mode,
                                logic [3:0] s, logic [3:0] t, logic e);
        vec_t v;
        v.en = en; v.sync = sync; v.we = we; v.ch = ch; v.div = div; v.mode = mode;
        v.exp_slow = s; v.exp_tick = t; v.exp_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.ch_enable = 4'b1111; bus.sync_restart = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_mode = 1'b0;
        bus3.ch_enable = 3'b111; bus3.sync_restart = 1'b0; bus3.cfg_we = 1'b0;
        bus3.cfg_ch = '0; bus3.cfg_div = '0; bus3.cfg_mode = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        reset = 1'b1;
        step();
        step();
        chk("reset_slow", 32'(bus.slow_clock), 32'h0);
        chk("reset_tick", 32'(bus.tick), 32'h0);
        chk("reset_err", 32'(bus.cfg_err), 32'h0);
        reset = 1'b0;

        // Default D=31250, toggle: first toggle/tick at edge 31250, next at 62500.
        repeat (31249) step();
        chk("def_pre_slow", 32'(bus.slow_clock), 32'h0);
        chk("def_pre_tick", 32'(bus.tick), 32'h0);
        step();
        chk("def_31250_slow", 32'(bus.slow_clock), 32'hf);
        chk("def_31250_tick", 32'(bus.tick), 32'hf);
        step();
        chk("def_31251_slow", 32'(bus.slow_clock), 32'hf);
        chk("def_31251_tick", 32'(bus.tick), 32'h0);
        repeat (31249) step();
        chk("def_62500_slow", 32'(bus.slow_clock), 32'h0);
        chk("def_62500_tick", 32'(bus.tick), 32'hf);

        // Fresh reset, then the cycle-by-cycle table (inputs before edge, outputs after).
        reset = 1'b1;
        step();
        reset = 1'b0;
        //                en       sy we ch div mo  slow     tick     err
        vecs.push_back(mk(4'b1111, 0, 1, 1, 3, 0, 4'b0000, 4'b0000, 0)); // ch1 D=3 toggle
        vecs.push_back(mk(4'b1111, 0, 1, 2, 4, 1, 4'b0000, 4'b0000, 0)); // ch2 D=4 pulse
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b0010, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0110, 4'b0100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0)); // ch1 count=1
        vecs.push_back(mk(4'b1101, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0)); // ch1 disabled x5
        vecs.push_back(mk(4'b1101, 0, 0, 0, 0, 0, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(4'b1101, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1101, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1101, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b0010, 0)); // 2nd enabled edge
        vecs.push_back(mk(4'b1111, 0, 1, 1, 0, 1, 4'b0010, 4'b0000, 1)); // div=0 rejected
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0100, 4'b0110, 0));
        vecs.push_back(mk(4'b1111, 0, 1, 3, 3, 0, 4'b0000, 4'b0000, 0)); // ch3 D=3
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 1, 1, 0, 3, 0, 4'b0000, 4'b0000, 0)); // restart + write
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1011, 4'b1011, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1111, 4'b0100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1011, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 4'b1011, 0));
        vecs.push_back(mk(4'b1111, 0, 1, 3, 1, 0, 4'b0000, 4'b0000, 0)); // ch3 D=1 toggle
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1100, 4'b1100, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0011, 4'b1011, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1011, 4'b1000, 0));
        vecs.push_back(mk(4'b1111, 0, 1, 2, 1, 1, 4'b0011, 4'b1000, 0)); // ch2 D=1 pulse
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b1100, 4'b1111, 0));
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0100, 4'b1100, 0));

        foreach (vecs[k]) begin
            bus.ch_enable    = vecs[k].en;
            bus.sync_restart = vecs[k].sync;
            bus.cfg_we       = vecs[k].we;
            bus.cfg_ch       = vecs[k].ch;
            bus.cfg_div      = vecs[k].div;
            bus.cfg_mode     = vecs[k].mode;
            step();
            chk($sformatf("v%0d_slow", k), 32'(bus.slow_clock), 32'(vecs[k].exp_slow));
            chk($sformatf("v%0d_tick", k), 32'(bus.tick), 32'(vecs[k].exp_tick));
            chk($sformatf("v%0d_err", k), 32'(bus.cfg_err), 32'(vecs[k].exp_err));
        end
        idle();

        // Reset mid-operation: outputs clear and D=1/D=3 settings are discarded.
        reset = 1'b1;
        step();
        chk("midrst_slow", 32'(bus.slow_clock), 32'h0);
        chk("midrst_tick", 32'(bus.tick), 32'h0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("post_rst%0d_slow", i), 32'(bus.slow_clock), 32'h0);
            chk($sformatf("post_rst%0d_tick", i), 32'(bus.tick), 32'h0);
        end

        // 3-channel instance (D=2 default): cfg_ch=3 is out of range and rejected.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd1; bus3.cfg_mode = 1'b1;
        step();
        bus3.cfg_we = 1'b0;
        chk("rng_e1_err", 32'(bus3.cfg_err), 32'h1);
        chk("rng_e1_slow", 32'(bus3.slow_clock), 32'h0);
        step();
        chk("rng_e2_err", 32'(bus3.cfg_err), 32'h0);
        chk("rng_e2_slow", 32'(bus3.slow_clock), 32'h7);
        chk("rng_e2_tick", 32'(bus3.tick), 32'h7);
        step();
        chk("rng_e3_slow", 32'(bus3.slow_clock), 32'h7);
        chk("rng_e3_tick", 32'(bus3.tick), 32'h0);
        step();
        chk("rng_e4_slow", 32'(bus3.slow_clock), 32'h0);
        chk("rng_e4_tick", 32'(bus3.tick), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
